// File: rtl/if_fetch_stage_pkg.sv
// Shared MIPS fetch definitions: state encoding,
// reset PC default and the IF/ID bundle.
package if_fetch_stage_pkg;

  localparam int InstrWidth = 32;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [InstrWidth-1:0] instr;
    logic [31:0]           pc;
    logic [31:0]           pcPlus4;
  } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between
// the fetch stage (master) and instruction memory (slave).
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic                  IMemReq;
  logic [31:0]           IMemAddr;
  logic                  IMemReady;
  logic [InstrWidth-1:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemReady,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemReady,
    output IMemData
  );
endinterface

// File: rtl/if_fetch_stage_add32.sv
// Plain 32-bit adder; wraps modulo 2^32 with no
// carry out.
module Add32 (
  input  logic [31:0] DataIn1,
  input  logic [31:0] DataIn2,
  output logic [31:0] DataOut
);
  assign DataOut = DataIn1 + DataIn2;
endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction fetch: PC, imem request,
// hold buffer for stalls, and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  if_fetch_stage_if.master imem,
  output logic [31:0] InstrOut,
  output logic [31:0] PCOut,
  output logic [31:0] PCPlus4Out,
  output logic        ValidOut
);

  fetch_state_t          state, stateNext;
  logic [31:0]           pc, pcNext;
  logic [31:0]           pcPlus4;
  logic [InstrWidth-1:0] holdBuf, holdBufNext;
  if_id_t                ifId, ifIdNext;
  logic                  valid, validNext;

  Add32 uPcAdd (
    .DataIn1 (pc),
    .DataIn2 (32'd4),
    .DataOut (pcPlus4)
  );

  assign imem.IMemReq  = (state == REQ) && !rst;
  assign imem.IMemAddr = pc;

  assign InstrOut   = ifId.instr;
  assign PCOut      = ifId.pc;
  assign PCPlus4Out = ifId.pcPlus4;
  assign ValidOut   = valid;

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    holdBufNext = holdBuf;
    ifIdNext    = ifId;
    validNext   = valid;
    // Redirects win over stalls and any same-cycle response
    if (BranchTaken) begin
      pcNext    = BranchTarget & ~32'h3;
      validNext = 1'b0;
      stateNext = REQ;
    end else if (Jump) begin
      pcNext    = JumpTarget & ~32'h3;
      validNext = 1'b0;
      stateNext = REQ;
    end else if (Flush) begin
      validNext = 1'b0;
      stateNext = REQ;
    end else begin
      case (state)
        REQ: begin
          if (imem.IMemReady && !Stall) begin
            ifIdNext  = '{imem.IMemData, pc, pcPlus4};
            validNext = 1'b1;
            pcNext    = pcPlus4;
          end else if (imem.IMemReady) begin
            holdBufNext = imem.IMemData;
            stateNext   = HOLD;
          end else if (!Stall) begin
            validNext = 1'b0;
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifIdNext  = '{holdBuf, pc, pcPlus4};
            validNext = 1'b1;
            pcNext    = pcPlus4;
            stateNext = REQ;
          end
        end
        default: stateNext = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      holdBuf <= '0;
      ifId    <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      holdBuf <= holdBufNext;
      ifId    <= ifIdNext;
      valid   <= validNext;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

MIPS instruction-fetch stage: owns the program counter, issues instruction-memory requests, and loads the IF/ID pipeline register. Next-PC is selected from PC+4, the branch target, or the jump target. Sits upstream of decode and the branch-target adder. Tolerates a variable-latency instruction memory and downstream stalls without losing or duplicating an instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- Stall  in  1  decode cannot accept; hold PC and IF/ID
- Flush  in  1  invalidate IF/ID and any held instruction; PC unchanged
- BranchTaken  in  1  redirect to BranchTarget (resolved in EX)
- BranchTarget  in  32  branch destination
- Jump  in  1  redirect to JumpTarget (resolved in ID)
- JumpTarget  in  32  jump destination
- IMemReq  out  1  fetch request valid
- IMemAddr  out  32  fetch address (= PC)
- IMemReady  in  1  IMemData valid for current IMemAddr this cycle
- IMemData  in  32  instruction word
- InstrOut  out  32  IF/ID instruction
- PCOut  out  32  IF/ID PC of InstrOut
- PCPlus4Out  out  32  IF/ID PC+4 of InstrOut
- ValidOut  out  1  IF/ID holds a real instruction

## Operation
- States: REQ (request outstanding), HOLD (instruction captured, downstream stalled).
- REQ: IMemReq=1, IMemAddr=PC.
  - IMemReady & !Stall: IF/ID <= {IMemData, PC, PC+4}, ValidOut<=1, PC<=PC+4.
  - IMemReady & Stall: capture into hold buffer, IF/ID unchanged, go HOLD.
  - !IMemReady & !Stall: ValidOut<=0 (bubble).
  - !IMemReady & Stall: IF/ID unchanged.
- HOLD: IMemReq=0, IMemAddr=PC. On !Stall: IF/ID <= buffer, ValidOut<=1, PC<=PC+4, go REQ.
- Redirect priority: rst > BranchTaken > Jump > Flush > normal. Redirect and Flush override Stall.
- BranchTaken/Jump: PC<=target with bits [1:0] forced to 00; ValidOut<=0; hold buffer discarded; go REQ. An IMemReady in the same cycle is ignored.
- Flush alone: ValidOut<=0, buffer discarded, go REQ, PC unchanged. The held instruction at PC is refetched.
- Arithmetic: PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Memory contract: IMemAddr may change only on redirect; memory must accept an address change while a request is pending.

## Timing
- Reset values: PC=RESET_PC, state=REQ, IMemReq=0 while rst=1, ValidOut=0, InstrOut=0, PCOut=0, PCPlus4Out=0.
- First request (IMemAddr=RESET_PC) is issued in the first cycle with rst=0.
- Zero-wait memory: ValidOut rises 1 cycle after IMemReady; throughput is 1 instruction/cycle.
- Redirect in cycle n: IMemAddr=target in cycle n+1; ValidOut=0 in n+1.
- HOLD release: IF/ID is loaded at the edge ending the first !Stall cycle; the next request issues that same next cycle.
- rst mid-operation: all state returns to reset values at the next edge; the pending request is abandoned.

## Structure
- Shared MIPS package: fetch state encoding (REQ, HOLD), RESET_PC default, instruction-width constant.
- One sub-module: the existing 32-bit adder Add32, instantiated for PC+4 with DataIn2=32'd4.
- Pure RTL, with no memories inferred beyond registers.

## Test plan
- Reset then zero-wait memory returning PC-based words for 4 cycles -> PCOut 0,4,8,C on consecutive cycles, ValidOut=1 from cycle 2 onward.
- IMemReady low for 3 cycles at PC=0x10 -> three ValidOut=0 bubbles, then InstrOut at 0x10, PCPlus4Out=0x14.
- Stall for 2 cycles while IMemReady=1 at PC=0x20 -> IMemReq=0 during HOLD; after release InstrOut is the 0x20 word, exactly once.
- BranchTaken=1 with BranchTarget=0x103 and Jump=1 with JumpTarget=0x200 in the same cycle, with Stall=1 -> next IMemAddr=0x100, ValidOut=0.
- RESET_PC=32'hFFFF_FFFC -> PCPlus4Out=0, next IMemAddr=0.
- rst asserted while in HOLD -> next cycle PC=RESET_PC, ValidOut=0, state REQ, held instruction never appears.
